// File: rtl/io_bridge.sv
// io_bridge: CPU data-port responder with data RAM and memory-mapped
// LEDs, switches, buttons, 8-digit 7-seg scan and a prescaled timer.
module io_bridge #(
   parameter int DRAM_AW   = 12,
   parameter int SCAN_DIV  = 50000,
   parameter int TIMER_DIV = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wData,
   input  logic        wen,
   output logic [31:0] rData,
   input  logic [23:0] sw,
   input  logic [4:0]  btn,
   output logic [23:0] led,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_dn
);

   localparam int SCW = $clog2(SCAN_DIV > 1 ? SCAN_DIV : 2);
   localparam int TPW = $clog2(TIMER_DIV > 1 ? TIMER_DIV : 2);

   localparam logic [29:0] W_DISP  = 30'h3FFF_FC00;
   localparam logic [29:0] W_TIMER = 30'h3FFF_FC08;
   localparam logic [29:0] W_LED   = 30'h3FFF_FC18;
   localparam logic [29:0] W_SW    = 30'h3FFF_FC1C;
   localparam logic [29:0] W_BTN   = 30'h3FFF_FC1E;

   logic [29:0] wa;
   logic        sel_ram, sel_disp, sel_timer, sel_led, sel_sw, sel_btn;

   logic [31:0] mem [2**DRAM_AW];
   logic [31:0] disp;
   logic [31:0] timer;
   logic [TPW-1:0] psc;
   logic [SCW-1:0] scnt;
   logic [2:0]  idx;
   logic [23:0] sw_s1, sw_s2;
   logic [4:0]  btn_s1, btn_s2;
   logic [3:0]  nib;
   logic [7:0]  font;

   assign wa        = addr[31:2];
   assign sel_ram   = (addr[31:DRAM_AW+2] == '0);
   assign sel_disp  = (wa == W_DISP);
   assign sel_timer = (wa == W_TIMER);
   assign sel_led   = (wa == W_LED);
   assign sel_sw    = (wa == W_SW);
   assign sel_btn   = (wa == W_BTN);

   always_ff @(posedge clk) begin
      if (wen && sel_ram) mem[addr[DRAM_AW+1:2]] <= wData;
   end

   always_comb begin
      rData = '0;
      unique case (1'b1)
         sel_ram:   rData = mem[addr[DRAM_AW+1:2]];
         sel_disp:  rData = disp;
         sel_timer: rData = timer;
         sel_led:   rData = {8'h0, led};
         sel_sw:    rData = {8'h0, sw_s2};
         sel_btn:   rData = {27'h0, btn_s2};
         default:   rData = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led    <= '0;
         disp   <= '0;
         sw_s1  <= '0;
         sw_s2  <= '0;
         btn_s1 <= '0;
         btn_s2 <= '0;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         btn_s1 <= btn;
         btn_s2 <= btn_s1;
         if (wen && sel_led)  led  <= wData[23:0];
         if (wen && sel_disp) disp <= wData;
      end
   end

   // a store wins over a prescaler wrap in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
         psc   <= '0;
      end else if (wen && sel_timer) begin
         timer <= wData;
         psc   <= '0;
      end else if (psc == TPW'(TIMER_DIV - 1)) begin
         timer <= timer + 32'd1;
         psc   <= '0;
      end else begin
         psc   <= psc + 1'b1;
      end
   end

   assign nib = disp[{idx, 2'b00} +: 4];

   always_comb begin
      font = 8'hFF;
      case (nib)
         4'h0: font = 8'hC0;
         4'h1: font = 8'hF9;
         4'h2: font = 8'hA4;
         4'h3: font = 8'hB0;
         4'h4: font = 8'h99;
         4'h5: font = 8'h92;
         4'h6: font = 8'h82;
         4'h7: font = 8'hF8;
         4'h8: font = 8'h80;
         4'h9: font = 8'h90;
         4'hA: font = 8'h88;
         4'hB: font = 8'h83;
         4'hC: font = 8'hC6;
         4'hD: font = 8'hA1;
         4'hE: font = 8'h86;
         4'hF: font = 8'h8E;
         default: font = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt   <= '0;
         idx    <= '0;
         seg_en <= 8'hFE;
         seg_dn <= 8'hC0;
      end else begin
         if (scnt == SCW'(SCAN_DIV - 1)) begin
            scnt <= '0;
            idx  <= idx + 3'd1;
         end else begin
            scnt <= scnt + 1'b1;
         end
         seg_en <= ~(8'b1 << idx);
         seg_dn <= font;
      end
   end

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed plus randomized bus traffic against a
// behavioural model of the memory map, timer, synchronizers and scan.
module tb_io_bridge;

   localparam int AW = 8;
   localparam int SD = 2;
   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wData, rData;
   logic        wen;
   logic [23:0] sw, led;
   logic [4:0]  btn;
   logic [7:0]  seg_en, seg_dn;

   io_bridge #(.DRAM_AW(AW), .SCAN_DIV(SD), .TIMER_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wData(wData), .wen(wen),
      .rData(rData), .sw(sw), .btn(btn), .led(led),
      .seg_en(seg_en), .seg_dn(seg_dn)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] fnt [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
      8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // model state
   int          n;
   logic [31:0] tload;
   int          tedge;
   logic [31:0] m_disp;
   logic [23:0] m_led;
   logic [31:0] ram [int];
   logic [23:0] sw_h [$];
   logic [4:0]  btn_h [$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit mread(input logic [31:0] a, output logic [31:0] v);
      logic [31:0] wb;
      int          wi;
      wb = {a[31:2], 2'b00};
      v  = '0;
      if (wb < 32'(4 * (2 ** AW))) begin
         wi = int'(a[31:2]);
         if (!ram.exists(wi)) return 1'b0;
         v = ram[wi];
      end else if (wb == 32'hFFFF_F000) v = m_disp;
      else if (wb == 32'hFFFF_F020) v = tload + 32'((n - tedge) / TD);
      else if (wb == 32'hFFFF_F060) v = {8'h0, m_led};
      else if (wb == 32'hFFFF_F070) v = (n >= 2) ? {8'h0, sw_h[$-1]} : 32'h0;
      else if (wb == 32'hFFFF_F078) v = (n >= 2) ? {27'h0, btn_h[$-1]} : 32'h0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      n = 0; tload = '0; tedge = 0; m_disp = '0; m_led = '0;
      sw_h.delete();
      btn_h.delete();
   endtask

   task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                      input logic w);
      logic [31:0] ev, old_disp, wb;
      int          k;
      addr = a; wData = d; wen = w;
      #1;
      if (mread(a, ev)) check("rdata", rData, ev);
      @(posedge clk);
      old_disp = m_disp;
      sw_h.push_back(sw);
      btn_h.push_back(btn);
      n++;
      wb = {a[31:2], 2'b00};
      if (w) begin
         if (wb < 32'(4 * (2 ** AW))) ram[int'(a[31:2])] = d;
         else if (wb == 32'hFFFF_F000) m_disp = d;
         else if (wb == 32'hFFFF_F020) begin tload = d; tedge = n; end
         else if (wb == 32'hFFFF_F060) m_led = d[23:0];
      end
      #1;
      k = ((n - 1) / SD) % 8;
      check("led", {8'h0, led}, {8'h0, m_led});
      check("seg_en", {24'h0, seg_en}, {24'h0, ~(8'b1 << k)});
      check("seg_dn", {24'h0, seg_dn}, {24'h0, fnt[old_disp[4*k +: 4]]});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      addr = 32'hFFFF_F020; wen = 1'b0;
      #2;
      check("rst_led", {8'h0, led}, 32'h0);
      check("rst_en", {24'h0, seg_en}, 32'hFE);
      check("rst_dn", {24'h0, seg_dn}, 32'hC0);
      check("rst_timer", rData, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   logic [31:0] ra, rd;
   int          sel;

   initial begin
      sw = '0; btn = '0; addr = '0; wData = '0; wen = 1'b0;
      rst_n = 1'b0;
      #12;
      do_reset();

      cyc(32'hFFFF_F000, 32'h8765_43A1, 1'b1);
      for (int i = 0; i < 20; i++) cyc(32'hFFFF_F000, 32'h0, 1'b0);

      cyc(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
      cyc(32'h0000_0014, 32'h1234_5678, 1'b1);
      cyc(32'h0000_0010, 32'h0, 1'b0);
      cyc(32'h0000_0014, 32'h0, 1'b0);
      cyc(32'h0000_0013, 32'h0, 1'b0);

      cyc(32'hFFFF_F060, 32'h00AB_CDEF, 1'b1);
      cyc(32'hFFFF_F060, 32'h0, 1'b0);

      sw = 24'h123456; btn = 5'h15;
      for (int i = 0; i < 4; i++) cyc(32'hFFFF_F070, 32'h0, 1'b0);
      cyc(32'hFFFF_F078, 32'h0, 1'b0);

      cyc(32'hFFFF_F100, 32'hFFFF_FFFF, 1'b1);
      cyc(32'hFFFF_F100, 32'h0, 1'b0);

      cyc(32'hFFFF_F020, 32'hFFFF_FFFF, 1'b1);
      for (int i = 0; i < 4; i++) cyc(32'hFFFF_F020, 32'h0, 1'b0);
      cyc(32'hFFFF_F020, 32'h0, 1'b0);
      cyc(32'hFFFF_F020, 32'h0, 1'b0);
      cyc(32'hFFFF_F020, 32'h0, 1'b0);
      cyc(32'hFFFF_F020, 32'h0000_0100, 1'b1);
      cyc(32'hFFFF_F020, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(32'hFFFF_F020, 32'h0, 1'b0);

      cyc(32'hFFFF_F000, 32'h0000_0005, 1'b1);
      cyc(32'hFFFF_F000, 32'h0, 1'b0);

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) sw = 24'($urandom);
         if ($urandom_range(0, 7) == 0) btn = 5'($urandom);
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1: ra = {22'h0, 6'($urandom_range(0, 15)), 2'($urandom)};
            2: ra = 32'hFFFF_F000;
            3: ra = 32'hFFFF_F020;
            4: ra = 32'hFFFF_F060;
            5: ra = 32'hFFFF_F070;
            6: ra = 32'hFFFF_F078;
            7: ra = 32'hFFFF_F100;
            8: ra = 32'hFFFF_F004 + 32'($urandom_range(0, 3));
            default: ra = $urandom;
         endcase
         rd = $urandom;
         if (sel == 3 && $urandom_range(0, 3) != 0)
            cyc(ra, rd, 1'b0);
         else
            cyc(ra, rd, 1'($urandom_range(0, 1)));
         if (i == 300) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
